// File: rtl/updown_counter_pkg.sv
// Shared mode encodings for the parametrised up/down counter.
package updown_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap, saturate and bounce modes,
// synchronous load and a registered terminal-count pulse.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 3,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 1..32");
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("updown_counter_param: RST_VAL must not exceed MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             max_hit, min_hit;
  mode_t            mode_s;

  assign mode_s  = mode_t'(mode);
  assign max_hit = (count_q == MAX);
  assign min_hit = (count_q == '0);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
      dir_d   = up_down;
    end else if (en) begin
      case (mode_s)
        MODE_WRAP: begin
          dir_d = up_down;
          if (up_down) begin
            if (max_hit) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + ONE;
            end
          end else begin
            if (min_hit) begin
              count_d = MAX;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        MODE_SAT: begin
          dir_d = up_down;
          if (up_down) begin
            if (max_hit) tc_d = 1'b1;
            else         count_d = count_q + ONE;
          end else begin
            if (min_hit) tc_d = 1'b1;
            else         count_d = count_q - ONE;
          end
        end
        MODE_BOUNCE: begin
          // Direction comes from the internal register; reversal happens on the
          // boundary edge itself so the ends are never dwelt on.
          if (dir_q) begin
            if (max_hit) begin
              count_d = MAX - ONE;
              dir_d   = 1'b0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + ONE;
            end
          end else begin
            if (min_hit) begin
              count_d = ONE;
              dir_d   = 1'b1;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RSTV;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign dir    = dir_q;
  assign tc     = tc_q;
  assign at_max = max_hit;
  assign at_min = min_hit;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param (MAX_VAL=5 and MAX_VAL=1 instances).
module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_down;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       dir;
  logic       tc;
  logic       at_max;
  logic       at_min;

  logic [1:0] load_val1;
  logic [1:0] count1;
  logic       dir1;
  logic       tc1;
  logic       at_max1;
  logic       at_min1;

  int checks;
  int failures;

  updown_counter_param #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode(mode),
    .load(load), .load_val(load_val), .count(count), .dir(dir), .tc(tc),
    .at_max(at_max), .at_min(at_min)
  );

  updown_counter_param #(.WIDTH(2), .MAX_VAL(1), .RST_VAL(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode(mode),
    .load(load), .load_val(load_val1), .count(count1), .dir(dir1), .tc(tc1),
    .at_max(at_max1), .at_min(at_min1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up_down = 1'b0; mode = 2'b00; load = 1'b1; load_val = 3'd3;
    tick(); tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%0b exp=1", dir); end
    checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%0b exp=0", tc); end
    checks++; if (at_min !== 1'b1 || at_max !== 1'b0) begin failures++; $display("FAIL reset_flags got min=%0b max=%0b exp min=1 max=0", at_min, at_max); end
  endtask

  task automatic test_wrap_up();
    logic [2:0] ec [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic       et [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b0; load = 1'b0; en = 1'b1; up_down = 1'b1; mode = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (count !== ec[i]) begin failures++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      checks++; if (tc !== et[i]) begin failures++; $display("FAIL wrap_up_tc[%0d] got=%0b exp=%0b", i, tc, et[i]); end
      checks++; if (at_max !== (ec[i] == 3'd5)) begin failures++; $display("FAIL wrap_up_at_max[%0d] got=%0b", i, at_max); end
    end
  endtask

  task automatic test_wrap_down();
    logic [2:0] ec [3] = '{3'd5, 3'd4, 3'd3};
    logic       et [3] = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; load_val = 3'd0; up_down = 1'b0; mode = 2'b00;
    tick();
    checks++; if (count !== 3'd0 || dir !== 1'b0) begin failures++; $display("FAIL wrap_down_load got=%0d/%0b exp=0/0", count, dir); end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== ec[i]) begin failures++; $display("FAIL wrap_down_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      checks++; if (tc !== et[i]) begin failures++; $display("FAIL wrap_down_tc[%0d] got=%0b exp=%0b", i, tc, et[i]); end
    end
  endtask

  task automatic test_sat();
    logic [2:0] ec [9] = '{3'd5, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic       et [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mode = 2'b01; load = 1'b1; load_val = 3'd4; up_down = 1'b1;
    tick();
    checks++; if (count !== 3'd4 || tc !== 1'b0) begin failures++; $display("FAIL sat_load got=%0d/%0b exp=4/0", count, tc); end
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up_down = (i < 3) ? 1'b1 : 1'b0;
      tick();
      if (i < 9) begin
        checks++; if (count !== ec[i]) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
        checks++; if (tc !== et[i]) begin failures++; $display("FAIL sat_tc[%0d] got=%0b exp=%0b", i, tc, et[i]); end
      end else begin
        checks++; if (count !== 3'd0 || tc !== 1'b1 || dir !== 1'b0) begin failures++; $display("FAIL sat_hold_min got=%0d/%0b/%0b exp=0/1/0", count, tc, dir); end
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] ec [9] = '{3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic       et [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ed [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    mode = 2'b10; load = 1'b1; load_val = 3'd3; up_down = 1'b1;
    tick();
    checks++; if (count !== 3'd3 || dir !== 1'b1) begin failures++; $display("FAIL bounce_load got=%0d/%0b exp=3/1", count, dir); end
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      up_down = 1'($urandom_range(1, 0));
      tick();
      checks++; if (count !== ec[i]) begin failures++; $display("FAIL bounce_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      checks++; if (tc !== et[i]) begin failures++; $display("FAIL bounce_tc[%0d] got=%0b exp=%0b", i, tc, et[i]); end
      checks++; if (dir !== ed[i]) begin failures++; $display("FAIL bounce_dir[%0d] got=%0b exp=%0b", i, dir, ed[i]); end
    end
  endtask

  task automatic test_load();
    mode = 2'b00; en = 1'b0; load = 1'b1; load_val = 3'd7; up_down = 1'b1;
    tick();
    checks++; if (count !== 3'd5 || dir !== 1'b1 || tc !== 1'b0) begin failures++; $display("FAIL load_clamp got=%0d/%0b/%0b exp=5/1/0", count, dir, tc); end
    en = 1'b1; load_val = 3'd2;
    tick();
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL load_over_en got=%0d exp=2", count); end
    load_val = 3'd0; up_down = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || tc !== 1'b0) begin failures++; $display("FAIL load_no_tc got=%0d/%0b exp=0/0", count, tc); end
    rst = 1'b1; load_val = 3'd4;
    tick();
    checks++; if (count !== 3'd0 || dir !== 1'b1) begin failures++; $display("FAIL rst_over_load got=%0d/%0b exp=0/1", count, dir); end
    rst = 1'b0; load_val = 3'd5; up_down = 1'b1;
    tick();
    load = 1'b0; mode = 2'b11; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (count !== 3'd5 || tc !== 1'b0 || dir !== 1'b1) begin failures++; $display("FAIL hold_mode[%0d] got=%0d/%0b/%0b exp=5/0/1", i, count, tc, dir); end
    end
  endtask

  task automatic test_enable_pause();
    logic [2:0] ec [3] = '{3'd4, 3'd5, 3'd0};
    logic       et [3] = '{1'b0, 1'b0, 1'b1};
    mode = 2'b10; load = 1'b1; load_val = 3'd5; up_down = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++; if (count !== 3'd4 || dir !== 1'b0 || tc !== 1'b1) begin failures++; $display("FAIL pause_setup got=%0d/%0b/%0b exp=4/0/1", count, dir, tc); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count !== 3'd4 || dir !== 1'b0 || tc !== 1'b0) begin failures++; $display("FAIL pause_hold[%0d] got=%0d/%0b/%0b exp=4/0/0", i, count, dir, tc); end
    end
    en = 1'b1;
    tick();
    checks++; if (count !== 3'd3 || tc !== 1'b0) begin failures++; $display("FAIL pause_resume got=%0d/%0b exp=3/0", count, tc); end
    mode = 2'b00; up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== ec[i] || tc !== et[i] || dir !== 1'b1) begin failures++; $display("FAIL pause_wrap[%0d] got=%0d/%0b/%0b exp=%0d/%0b/1", i, count, tc, dir, ec[i], et[i]); end
    end
  endtask

  task automatic test_bounce_max1();
    logic [1:0] ec [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic       et [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0; mode = 2'b10; en = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count1 !== ec[i] || tc1 !== et[i]) begin failures++; $display("FAIL max1_bounce[%0d] got=%0d/%0b exp=%0d/%0b", i, count1, tc1, ec[i], et[i]); end
    end
    load = 1'b1; load_val1 = 2'd3;
    tick();
    checks++; if (count1 !== 2'd1 || at_max1 !== 1'b1 || at_min1 !== 1'b0) begin failures++; $display("FAIL max1_load_clamp got=%0d max=%0b min=%0b exp=1/1/0", count1, at_max1, at_min1); end
    load = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; up_down = 1'b1; mode = 2'b00; load = 1'b0;
    load_val = 3'd0; load_val1 = 2'd0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_sat();
    test_bounce();
    test_load();
    test_enable_pause();
    test_bounce_max1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
